// File: rtl/button_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
// Optional auto-repeat on the "next" key: define BTN_AUTOREPEAT_EN.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One key: 2-flop synchronizer, stability counter, debounce FSM.
// Hold/repeat logic exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    btn_state_t       state_q, state_d;
    logic             press_pulse;
    logic             rep_pulse;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        press_pulse = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!sync2_q) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_PEND: begin
                if (sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    stable_d    = 1'b0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync2_q) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_PEND: begin
                // A bounce back to 0 returns to PRESSED without a new pulse
                if (!sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d  = RELEASED;
                    cnt_d    = '0;
                    stable_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = RELEASED;
                cnt_d    = '0;
                stable_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= RELEASED;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int HW =
                $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);

            logic [HW-1:0] hold_q, hold_d;
            logic          phase_q, phase_d;
            logic          fire;

            // phase 0 waits out the hold time, phase 1 paces repeats
            always_comb begin
                hold_d  = '0;
                phase_d = 1'b0;
                fire    = 1'b0;
                if (state_q == PRESSED && !sync2_q) begin
                    if (!phase_q &&
                        hold_q == HW'(HOLD_CYCLES - 1)) begin
                        fire    = 1'b1;
                        phase_d = 1'b1;
                    end else if (phase_q &&
                        hold_q == HW'(REPEAT_CYCLES - 1)) begin
                        fire    = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        hold_d  = hold_q + HW'(1);
                        phase_d = phase_q;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q  <= '0;
                    phase_q <= 1'b0;
                end else begin
                    hold_q  <= hold_d;
                    phase_q <= phase_d;
                end
            end

            assign rep_pulse = fire;
        end else begin : g_no_repeat
            assign rep_pulse = 1'b0;
        end
    endgenerate
`else
    assign rep_pulse = 1'b0;
`endif

    assign press = press_pulse | rep_pulse;

endmodule

// File: rtl/button_debouncer.sv
// Debounces the two active-low menu keys into single-cycle pulses.
// Optional auto-repeat on "next" when BTN_AUTOREPEAT_EN is defined.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_next_n,
    input  logic key_select_n,
    output logic button_next,
    output logic button_select
);

    logic next_pulse;
    logic select_pulse;
    logic button_next_q, button_next_d;
    logic button_select_q, button_select_d;

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b1)
    ) u_next (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_next_n),
        .press (next_pulse)
    );

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_EN       (1'b0)
    ) u_select (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_select_n),
        .press (select_pulse)
    );

    // Select wins a collision; the dropped next pulse is not deferred
    always_comb begin
        button_select_d = select_pulse;
        button_next_d   = next_pulse & ~select_pulse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            button_next_q   <= 1'b0;
            button_select_q <= 1'b0;
        end else begin
            button_next_q   <= button_next_d;
            button_select_q <= button_select_d;
        end
    end

    assign button_next   = button_next_q;
    assign button_select = button_select_q;

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Front-end conditioner for the two menu pushbuttons. It synchronizes the raw active-low board keys, debounces each one with a stability counter, and emits exactly one single-cycle pulse per accepted press on `button_next` / `button_select`. It sits directly upstream of the selector stage, which registers these pulses into `next` / `select`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Legal range is ≥ 2.
- `HOLD_CYCLES`, default 25000000: press duration before auto-repeat starts. Used only with `BTN_AUTOREPEAT_EN`.
- `REPEAT_CYCLES`, default 10000000: period between auto-repeat pulses. Used only with `BTN_AUTOREPEAT_EN`.
- `clk` input 1: system clock. The block has one clock.
- `rst` input 1: reset. It is synchronous and active-high.
- `key_next_n` input 1: raw "next" key, active-low, asynchronous.
- `key_select_n` input 1: raw "select" key, active-low, asynchronous.
- `button_next` output 1: single-cycle pulse per accepted "next" press.
- `button_select` output 1: single-cycle pulse per accepted "select" press.

## Operation
- **Synchronizer:** each key passes through a 2-flop synchronizer. Its reset value is 1, meaning released.
- **Per-key state:**
  - accepted level `stable`, reset 1
  - counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, reset 0
  - FSM
- **FSM states:**
  - `RELEASED`: `stable`=1.
  - `PRESS_PEND`: sync=0, counting.
  - `PRESSED`: `stable`=0.
  - `RELEASE_PEND`: sync=1, counting.
- **FSM transitions:**
  - `RELEASED` → `PRESS_PEND` when sync=0, with `cnt`←1.
  - `PRESS_PEND`: if sync=1, go to `RELEASED` with `cnt`←0 (a bounce discards the count). Otherwise `cnt`++. When `cnt` reaches `DEBOUNCE_CYCLES`, go to `PRESSED` and fire one press pulse.
  - `PRESSED` → `RELEASE_PEND` when sync=1. `RELEASE_PEND` mirrors `PRESS_PEND`. On completion it goes to `RELEASED` with no pulse.
  - `cnt` never exceeds `DEBOUNCE_CYCLES`, so there is no wrap-around.
- **Release pulses:** releases produce no output pulse. A bounce during `RELEASE_PEND` returns to `PRESSED` and does not re-fire.
- **Simultaneous presses:** if both channels would pulse in the same cycle, `button_select` fires and the `button_next` pulse is dropped, not deferred. Outputs are never both 1.
- **Outputs:** registered. Reset value of `button_next` and `button_select` is 0.
- **Reset mid-operation:** `rst` returns all FSMs to `RELEASED`, clears counters, sets synchronizers to 1 and clears outputs on that edge. A key still held after reset must be re-debounced and then produces one pulse.

## Timing
- With a key falling before edge N and held clean, the pulse is high exactly during cycle N+2+`DEBOUNCE_CYCLES`. This counts 2 synchronizer cycles plus the count.
- The pulse width is always exactly 1 cycle.
- Minimum spacing between two accepted presses of the same key is 2·`DEBOUNCE_CYCLES`+2 cycles.
- `enable` gating is not this block's job. Pulses are produced regardless of downstream enable.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - While the "next" channel stays in `PRESSED`, a hold counter runs.
  - After `HOLD_CYCLES` cycles beyond the initial pulse, it emits a repeat pulse, then one every `REPEAT_CYCLES`.
  - Leaving `PRESSED` clears the hold counter.
  - The "select" channel never repeats.
  - Repeat pulses obey the select-priority rule.
- `BTN_AUTOREPEAT_EN` undefined:
  - The hold/repeat logic and counters are absent.
  - Exactly one pulse per press.
  - `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.

## Structure
- Shared package `button_pkg`:
  - FSM state enum `btn_state_t` (`RELEASED`, `PRESS_PEND`, `PRESSED`, `RELEASE_PEND`)
  - default debounce, hold and repeat constants
- Sub-module `btn_channel`:
  - Contains synchronizer, counter, FSM and optional hold/repeat logic.
  - Instantiated twice; the repeat capability is enabled only for the "next" instance via a parameter.
- Top level holds the select-priority arbitration and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 (and `HOLD_CYCLES`=8, `REPEAT_CYCLES`=3 where applicable).
- **Clean press:** `key_next_n` falls before edge 10 and is held 20 cycles → `button_next`=1 only in cycle 16; `button_select` stays 0.
- **Bouncy press:** `key_select_n` pattern 0,1,0,0,1,0,0,0,0 then held → exactly one `button_select` pulse, 6 cycles after the final 0-run begins. No pulse from the short runs.
- **Release bounce:** hold "next", release with 1,0,1,1,1,1 → no additional `button_next` pulses. The next clean press yields one pulse.
- **Simultaneous:** both keys fall on the same cycle → `button_select` pulses in cycle N+6; `button_next` stays 0 throughout.
- **Reset mid-count:** `rst` asserted at `cnt`=3 while "next" is held, then deasserted → no pulse before reset; exactly one pulse 6 cycles after release of reset.
- **`BTN_AUTOREPEAT_EN` defined:** hold "next" 30 cycles → pulses at cycles N+6, N+14, N+17, N+20, …; select held → single pulse.
